// File: rtl/pmem_responder_if.sv
// Instruction-fetch read channel plus host load port between the program-memory
// cache/host side (master) and the SRAM responder (slave).
interface pmem_responder_if #(
    parameter int unsigned ADDR_BITS    = 8,
    parameter int unsigned DATA_BITS    = 16,
    parameter int unsigned NUM_CHANNELS = 2
);
    logic [NUM_CHANNELS-1:0]                mem_read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address;
    logic [NUM_CHANNELS-1:0]                mem_read_ready;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data;
    logic                                   load_valid;
    logic [ADDR_BITS-1:0]                   load_address;
    logic [DATA_BITS-1:0]                   load_data;

    modport master (
        output mem_read_valid,
        output mem_read_address,
        input  mem_read_ready,
        input  mem_read_data,
        output load_valid,
        output load_address,
        output load_data
    );

    modport slave (
        input  mem_read_valid,
        input  mem_read_address,
        output mem_read_ready,
        output mem_read_data,
        input  load_valid,
        input  load_address,
        input  load_data
    );
endinterface

// File: rtl/pmem_responder.sv
// Program-memory responder: per-channel request FSMs sharing one single-port word array.
// Optional feature: define PMEM_BOUNDS_CHECK_EN to zero reads / drop loads at address >= MEM_DEPTH.
module pmem_responder #(
    parameter int unsigned ADDR_BITS    = 8,
    parameter int unsigned DATA_BITS    = 16,
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned MEM_DEPTH    = 256,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    pmem_responder_if.slave   bus
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned PTR_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_QUEUED,
        ST_WAIT,
        ST_RESPOND
    } state_t;

    logic [DATA_BITS-1:0] mem [MEM_DEPTH];

    state_t                                 state_q [NUM_CHANNELS];
    logic [IDX_W-1:0]                       addr_q  [NUM_CHANNELS];
    logic [CNT_W-1:0]                       cnt_q   [NUM_CHANNELS];
    logic [DATA_BITS-1:0]                   buf_q   [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]                ready_q;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] data_q;
    logic [PTR_W-1:0]                       ptr_q;

    logic                 grant_valid;
    logic [PTR_W-1:0]     grant_idx;
    logic [DATA_BITS-1:0] rdata;
    logic                 load_en;

    // Modulo form aliases out-of-range addresses onto the array.
    function automatic logic [IDX_W-1:0] to_index(input logic [ADDR_BITS-1:0] a);
        return IDX_W'(32'(a) % MEM_DEPTH);
    endfunction

`ifdef PMEM_BOUNDS_CHECK_EN
    logic oob_q [NUM_CHANNELS];

    function automatic logic out_of_range(input logic [ADDR_BITS-1:0] a);
        return 32'(a) >= MEM_DEPTH;
    endfunction

    assign load_en = reset && bus.load_valid && !out_of_range(bus.load_address);
    assign rdata   = oob_q[grant_idx] ? '0 : mem[addr_q[grant_idx]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) oob_q[i] <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (state_q[i] == ST_IDLE && bus.mem_read_valid[i])
                    oob_q[i] <= out_of_range(bus.mem_read_address[i]);
            end
        end
    end
`else
    assign load_en = reset && bus.load_valid;
    assign rdata   = mem[addr_q[grant_idx]];
`endif

    // Array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (load_en) mem[to_index(bus.load_address)] <= bus.load_data;
    end

    // Round-robin pick among QUEUED channels; a load owns the port for its cycle.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (!bus.load_valid) begin
            for (int unsigned off = 0; off < NUM_CHANNELS; off++) begin
                if (!grant_valid &&
                    state_q[PTR_W'((32'(ptr_q) + off) % NUM_CHANNELS)] == ST_QUEUED) begin
                    grant_valid = 1'b1;
                    grant_idx   = PTR_W'((32'(ptr_q) + off) % NUM_CHANNELS);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q   <= '0;
            ready_q <= '0;
            data_q  <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state_q[i] <= ST_IDLE;
                addr_q[i]  <= '0;
                cnt_q[i]   <= '0;
                buf_q[i]   <= '0;
            end
        end else begin
            if (grant_valid)
                ptr_q <= (grant_idx == PTR_W'(NUM_CHANNELS - 1)) ? '0 : grant_idx + PTR_W'(1);
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (bus.mem_read_valid[i]) begin
                            addr_q[i]  <= to_index(bus.mem_read_address[i]);
                            state_q[i] <= ST_QUEUED;
                        end
                    end
                    ST_QUEUED: begin
                        if (grant_valid && grant_idx == PTR_W'(i)) begin
                            buf_q[i] <= rdata;
                            if (READ_LATENCY == 1) begin
                                ready_q[i] <= 1'b1;
                                data_q[i]  <= rdata;
                                state_q[i] <= ST_RESPOND;
                            end else begin
                                cnt_q[i]   <= CNT_W'(READ_LATENCY - 1);
                                state_q[i] <= ST_WAIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                        if (cnt_q[i] == CNT_W'(1)) begin
                            ready_q[i] <= 1'b1;
                            data_q[i]  <= buf_q[i];
                            state_q[i] <= ST_RESPOND;
                        end
                    end
                    ST_RESPOND: begin
                        // Valid may already be low here if it dropped early: one-cycle pulse.
                        if (!bus.mem_read_valid[i]) begin
                            ready_q[i] <= 1'b0;
                            data_q[i]  <= '0;
                            state_q[i] <= ST_IDLE;
                        end
                    end
                    default: state_q[i] <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.mem_read_ready = ready_q;
    assign bus.mem_read_data  = data_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: four instances (default, latency 1, latency 4,
// 128-word array) share one stimulus; expectations are hand-computed.
module tb_pmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  valid = '0;
    logic [7:0]  addr0 = '0;
    logic [7:0]  addr1 = '0;
    logic        ld_v = 1'b0;
    logic [7:0]  ld_a = '0;
    logic [15:0] ld_d = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int lat_m0, lat_m1, lat_l1, lat_l4, lat_d;
    int bad;

    always #5 clk = ~clk;

    pmem_responder_if #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(2)) b_main ();
    pmem_responder_if #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(2)) b_l1 ();
    pmem_responder_if #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(2)) b_l4 ();
    pmem_responder_if #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(2)) b_d128 ();

    assign b_main.mem_read_valid   = valid;
    assign b_main.mem_read_address = {addr1, addr0};
    assign b_main.load_valid       = ld_v;
    assign b_main.load_address     = ld_a;
    assign b_main.load_data        = ld_d;
    assign b_l1.mem_read_valid     = valid;
    assign b_l1.mem_read_address   = {addr1, addr0};
    assign b_l1.load_valid         = ld_v;
    assign b_l1.load_address       = ld_a;
    assign b_l1.load_data          = ld_d;
    assign b_l4.mem_read_valid     = valid;
    assign b_l4.mem_read_address   = {addr1, addr0};
    assign b_l4.load_valid         = ld_v;
    assign b_l4.load_address       = ld_a;
    assign b_l4.load_data          = ld_d;
    assign b_d128.mem_read_valid   = valid;
    assign b_d128.mem_read_address = {addr1, addr0};
    assign b_d128.load_valid       = ld_v;
    assign b_d128.load_address     = ld_a;
    assign b_d128.load_data        = ld_d;

    pmem_responder u_main (.clk(clk), .reset(rst), .bus(b_main.slave));
    pmem_responder #(.READ_LATENCY(1)) u_l1 (.clk(clk), .reset(rst), .bus(b_l1.slave));
    pmem_responder #(.READ_LATENCY(4)) u_l4 (.clk(clk), .reset(rst), .bus(b_l4.slave));
    pmem_responder #(.MEM_DEPTH(128)) u_d128 (.clk(clk), .reset(rst), .bus(b_d128.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] a, input logic [15:0] d);
        ld_a = a;
        ld_d = d;
        ld_v = 1'b1;
        tick();
        ld_v = 1'b0;
    endtask

    // Ticks up to 'cycles' edges; latency = edges after the edge that sampled valid.
    // ld_v is high on edges ld_from..ld_to (0 = none).
    task automatic measure(input int cycles, input int ld_from, input int ld_to);
        lat_m0 = -1; lat_m1 = -1; lat_l1 = -1; lat_l4 = -1; lat_d = -1;
        for (int t = 1; t <= cycles; t++) begin
            ld_v = (t >= ld_from && t <= ld_to && ld_from > 0);
            tick();
            if (lat_m0 < 0 && b_main.mem_read_ready[0]) lat_m0 = t - 1;
            if (lat_m1 < 0 && b_main.mem_read_ready[1]) lat_m1 = t - 1;
            if (lat_l1 < 0 && b_l1.mem_read_ready[0])   lat_l1 = t - 1;
            if (lat_l4 < 0 && b_l4.mem_read_ready[0])   lat_l4 = t - 1;
            if (lat_d  < 0 && b_d128.mem_read_ready[0]) lat_d  = t - 1;
        end
        ld_v = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_ready", 32'(b_main.mem_read_ready), 32'h0);
        check("rst_data", 32'(b_main.mem_read_data), 32'h0);
        check("rst_ready_l4", 32'(b_l4.mem_read_ready), 32'h0);
        rst = 1'b1;
        tick();

        do_load(8'h05, 16'hA1B2);
        do_load(8'h01, 16'h1111);
        do_load(8'h02, 16'h2222);

        // Contention, pointer at 0: ch0 first
        valid = 2'b11; addr0 = 8'h01; addr1 = 8'h02;
        measure(8, 0, 0);
        check("cont1_lat_ch0", 32'(lat_m0), 32'd2);
        check("cont1_lat_ch1", 32'(lat_m1), 32'd3);
        check("cont1_data_ch0", 32'(b_main.mem_read_data[0]), 32'h1111);
        check("cont1_data_ch1", 32'(b_main.mem_read_data[1]), 32'h2222);
        valid = 2'b00;
        tick();
        check("cont1_drop_ready", 32'(b_main.mem_read_ready), 32'h0);
        check("cont1_drop_data", 32'(b_main.mem_read_data), 32'h0);

        // Single read and latency sweep on ch0
        valid = 2'b01; addr0 = 8'h05;
        measure(6, 0, 0);
        check("single_lat", 32'(lat_m0), 32'd2);
        check("lat1_lat", 32'(lat_l1), 32'd1);
        check("lat4_lat", 32'(lat_l4), 32'd4);
        check("single_data", 32'(b_main.mem_read_data[0]), 32'hA1B2);
        check("lat4_data", 32'(b_l4.mem_read_data[0]), 32'hA1B2);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!b_main.mem_read_ready[0] || b_main.mem_read_data[0] != 16'hA1B2) bad++;
            if (!b_l1.mem_read_ready[0]   || b_l1.mem_read_data[0]   != 16'hA1B2) bad++;
            if (!b_l4.mem_read_ready[0]   || b_l4.mem_read_data[0]   != 16'hA1B2) bad++;
        end
        check("hold_stable", 32'(bad), 32'd0);
        valid = 2'b00;
        tick();
        check("single_drop_ready", 32'(b_main.mem_read_ready[0]), 32'h0);
        check("single_drop_data", 32'(b_main.mem_read_data[0]), 32'h0);
        check("lat1_drop_ready", 32'(b_l1.mem_read_ready[0]), 32'h0);

        // Contention, pointer now at 1: ch1 first
        valid = 2'b11; addr0 = 8'h01; addr1 = 8'h02;
        measure(8, 0, 0);
        check("cont2_lat_ch1", 32'(lat_m1), 32'd2);
        check("cont2_lat_ch0", 32'(lat_m0), 32'd3);
        valid = 2'b00;
        tick();

        // Load blocking: three load cycles while QUEUED, load hits requested address
        valid = 2'b01; addr0 = 8'h01; ld_a = 8'h01; ld_d = 16'h3333;
        measure(10, 2, 4);
        check("ldblk_lat", 32'(lat_m0), 32'd5);
        check("ldblk_data", 32'(b_main.mem_read_data[0]), 32'h3333);
        valid = 2'b00;
        tick();

        // Load after grant does not disturb buffered word
        valid = 2'b01; addr0 = 8'h02; ld_a = 8'h02; ld_d = 16'h4444;
        measure(6, 3, 3);
        check("postgrant_lat", 32'(lat_m0), 32'd2);
        check("postgrant_data", 32'(b_main.mem_read_data[0]), 32'h2222);
        valid = 2'b00;
        tick();

        // Reset while ch0 is in WAIT; load during reset must be ignored
        valid = 2'b01; addr0 = 8'h05;
        tick();
        tick();
        rst = 1'b0; valid = 2'b00;
        ld_a = 8'h05; ld_d = 16'hDEAD; ld_v = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (b_main.mem_read_ready != 2'b00) bad++;
        end
        check("midrst_ready", 32'(bad), 32'd0);
        ld_v = 1'b0; rst = 1'b1;
        tick();
        check("postrst_ready", 32'(b_main.mem_read_ready), 32'h0);
        valid = 2'b01; addr0 = 8'h05;
        measure(6, 0, 0);
        check("postrst_lat", 32'(lat_m0), 32'd2);
        check("postrst_data", 32'(b_main.mem_read_data[0]), 32'hA1B2);
        valid = 2'b00;
        tick();

        // Out-of-range request on the 128-word instance
        do_load(8'h05, 16'hBEEF);
        valid = 2'b01; addr0 = 8'h85;
        measure(6, 0, 0);
        check("bounds_lat", 32'(lat_d), 32'd2);
`ifdef PMEM_BOUNDS_CHECK_EN
        check("bounds_data", 32'(b_d128.mem_read_data[0]), 32'h0000);
`else
        check("bounds_data", 32'(b_d128.mem_read_data[0]), 32'hBEEF);
`endif
        valid = 2'b00;
        tick();
        check("final_ready", 32'(b_d128.mem_read_ready), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pmem_responder.md
# pmem_responder

Program-memory responder: the SRAM end of the instruction-fetch read channel. It answers per-channel `mem_read_valid`/`mem_read_address` requests from the program-memory cache with `mem_read_ready`/`mem_read_data`, using a single-port word array shared by all channels. A host-side load port writes the program image before the cores run.

## Interface
- `ADDR_BITS`, 8: request address width.
- `DATA_BITS`, 16: instruction word width.
- `NUM_CHANNELS`, 2: independent request channels.
- `MEM_DEPTH`, 256: words in the array. Must be a power of two and ≤ 2**`ADDR_BITS`.
- `READ_LATENCY`, 2: cycles from grant to `mem_read_ready`. Must be ≥1.

Ports:
- `clk` input 1: sole clock, all logic on rising edge.
- `reset` input 1: synchronous, active-low (asserted when 0).
- `mem_read_valid` input `NUM_CHANNELS`: per-channel request.
- `mem_read_address` input `ADDR_BITS` × `NUM_CHANNELS`: request address.
- `mem_read_ready` output `NUM_CHANNELS`: per-channel response valid.
- `mem_read_data` output `DATA_BITS` × `NUM_CHANNELS`: response word.
- `load_valid` input 1: host write strobe.
- `load_address` input `ADDR_BITS`: host write address.
- `load_data` input `DATA_BITS`: host write word.

## Operation
Each channel has its own FSM with states IDLE, QUEUED, WAIT and RESPOND. Per channel it also holds a latched address, a data buffer and a latency counter.

- **IDLE:** on an edge with `mem_read_valid[i]`=1, latch the address and go to QUEUED.
- **QUEUED:** request array access. When granted, read the array into the data buffer at that edge.
  - If `READ_LATENCY`=1, go to RESPOND.
  - Otherwise load the counter with `READ_LATENCY`-1 and go to WAIT.
- **WAIT:** decrement the counter each edge. At the edge where the counter equals 1, go to RESPOND.
- **RESPOND:** `mem_read_ready[i]`=1 and `mem_read_data[i]` equals the buffer, both held stable. On an edge with `mem_read_valid[i]`=0, clear ready, clear data to 0 and go to IDLE.

Arbitration and the load port:
- At most one read grant per cycle, round-robin among QUEUED channels.
- The round-robin pointer resets to channel 0. After a grant it moves to the granted channel + 1, wrapping at `NUM_CHANNELS`.
- `load_valid`=1 writes `load_data` at that edge and takes the array port. No read grant occurs in that cycle.
- Address changes while a channel is in QUEUED, WAIT or RESPOND are ignored; the latched address is used.
- If valid drops before RESPOND (a protocol violation), the request still completes. Ready then pulses for exactly one cycle.
- A load to the address of an already-granted read does not alter the buffered data. A load before the grant is visible to that read.

## Timing
Reset and latency:
- **Reset (`reset`=0):**
  - All `mem_read_ready` and `mem_read_data` outputs are 0.
  - All FSMs go to IDLE, the pointer goes to 0 and the counters go to 0.
  - Loads are ignored.
  - The array is not cleared; contents survive reset.
- Reset asserted mid-request aborts the request. The next edge after release starts from IDLE.
- **Uncontended latency:** valid sampled at edge k gives ready high after edge k+`READ_LATENCY`. Each lost arbitration or load-blocked cycle adds 1.

Handshake:
- A new request needs valid low for ≥1 edge after RESPOND. Because valid is sampled low on the edge that leaves RESPOND, back-to-back requests are spaced at least 2 cycles apart.
- Simultaneous valid on all channels: grants are issued in pointer order, one per cycle.

## Configuration
- `PMEM_BOUNDS_CHECK_EN` defined: a request with address ≥ `MEM_DEPTH` returns 0, and a load to such an address is dropped.
- Not defined: the index is `address[$clog2(MEM_DEPTH)-1:0]`, so out-of-range addresses alias. Loads alias the same way.
- Has no effect when `MEM_DEPTH` = 2**`ADDR_BITS`.

## Test plan
All scenarios use defaults unless stated.
- **Single read:** load addr 0x05=0xA1B2, channel 0 requests 0x05 → ready after 2 edges with data 0xA1B2. Drop valid → ready=0 and data=0 next edge.
- **Contention:** both channels request at the same edge (addresses 0x01=0x1111, 0x02=0x2222) → ch0 ready at +2, ch1 at +3. Second simultaneous round → ch1 is served first.
- **Load blocking:** `load_valid` held 3 cycles while ch0 is QUEUED → ch0 ready 3 cycles late. Loading the requested address before the grant → new value returned.
- **Reset mid-request:** `reset`=0 while ch0 is in WAIT → ready stays 0. After release, re-request returns the word loaded before reset.
- **Bounds check:** `MEM_DEPTH`=128, request 0x85 where 0x05=0xBEEF → returns 0x0000 with the macro defined, 0xBEEF without.
- **Latency sweep:** `READ_LATENCY`=1 and 4 → ready after 1 and 4 edges respectively; data stays stable while valid is held for 10 cycles.
